// File: rtl/radial_sector_gen_if.sv
// radial_sector_gen_if -- pixel-side bus of the radial sector pattern generator.
//   x, y        : pixel column / line
//   active      : visible-area flag
//   next_frame  : one-cycle frame pulse
//   step_size   : per-frame rotation step
//   mode        : motion mode (0 add, 1 sub, 2 ping-pong, 3 freeze)
//   rgb         : registered RRGGBB colour back from the generator
// master = timing source driving coordinates, slave = generator.
interface radial_sector_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       next_frame;
  logic [2:0] step_size;
  logic [1:0] mode;
  logic [5:0] rgb;

  modport master (output x, y, active, next_frame, step_size, mode, input rgb);
  modport slave  (input x, y, active, next_frame, step_size, mode, output rgb);
endinterface

// File: rtl/radial_sector_gen.sv
// radial_sector_gen -- rotating radial sector (spiral arm) pattern.
// Each pixel gets an angle from its quadrant/octant relative to the centre plus
// a per-frame rotation offset; subtracting the ring (Manhattan radius band)
// twists the sectors into spiral arms. Arms alternate colour / gap.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : radial_sector_gen_if.slave (x, y, active, next_frame, step_size,
//           mode in; rgb out, registered one clk after x/y/active)
// Optional feature: define RADIAL_PALETTE_CYCLE_EN to rotate the palette by one
// entry every 64 frames.
module radial_sector_gen #(
  parameter int H_CENTER     = 320,
  parameter int V_CENTER     = 240,
  parameter int ARM_BITS     = 2,
  parameter int RING_SHIFT   = 4,
  parameter int SWING_FRAMES = 120
) (
  input  logic                 clk,
  input  logic                 rst_n,
  radial_sector_gen_if.slave   bus
);

  localparam logic [9:0] HC      = 10'(H_CENTER);
  localparam logic [9:0] VC      = 10'(V_CENTER);
  localparam logic [7:0] SW_LAST = 8'(SWING_FRAMES - 1);

  typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

  dir_t       state;
  logic [7:0] rot_acc;
  logic [7:0] pp_cnt;
  logic [7:0] step8;

  assign step8 = {5'b0, bus.step_size};

  // Rotation accumulator + ping-pong FSM. Any non ping-pong frame re-arms the
  // swing so mode 2 always starts forward from a zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FWD;
      rot_acc <= 8'd0;
      pp_cnt  <= 8'd0;
    end else if (bus.next_frame) begin
      if (bus.mode != 2'd2) begin
        state  <= FWD;
        pp_cnt <= 8'd0;
      end
      case (bus.mode)
        2'd0: rot_acc <= rot_acc + step8;
        2'd1: rot_acc <= rot_acc - step8;
        2'd2: begin
          rot_acc <= (state == FWD) ? rot_acc + step8 : rot_acc - step8;
          if (pp_cnt == SW_LAST) begin
            state  <= (state == FWD) ? REV : FWD;
            pp_cnt <= 8'd0;
          end else begin
            pp_cnt <= pp_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [2:0] pal_off;
`ifdef RADIAL_PALETTE_CYCLE_EN
  logic [5:0] pf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_cnt  <= 6'd0;
      pal_off <= 3'd0;
    end else if (bus.next_frame) begin
      pf_cnt <= pf_cnt + 6'd1;
      if (pf_cnt == 6'd63) pal_off <= pal_off + 3'd1;
    end
  end
`else
  assign pal_off = 3'd0;
`endif

  function automatic logic [5:0] pal_lut(input logic [2:0] i);
    case (i)
      3'd0:    pal_lut = 6'b010001;
      3'd1:    pal_lut = 6'b100011;
      3'd2:    pal_lut = 6'b111010;
      3'd3:    pal_lut = 6'b001110;
      3'd4:    pal_lut = 6'b110000;
      3'd5:    pal_lut = 6'b000011;
      3'd6:    pal_lut = 6'b101101;
      default: pal_lut = 6'b011111;
    endcase
  endfunction

  logic       xge, yge;
  logic [9:0] dx, dy, radius;
  logic [5:0] ring, angle;
  logic [6:0] phase;
  logic [2:0] arm3, pal_idx;
  logic       gap, lit;

  always_comb begin
    xge     = bus.x >= HC;
    yge     = bus.y >= VC;
    dx      = xge ? bus.x - HC : HC - bus.x;
    dy      = yge ? bus.y - VC : VC - bus.y;
    radius  = dx + dy;
    ring    = 6'(radius >> RING_SHIFT);
    // rot_off is rot_acc[7:2]; the low bits give sub-step smoothing only.
    angle   = {xge, yge, (dx > dy), 3'b000} + 6'(rot_acc >> 2);
    // Bit 6 set means the ring overtook the angle: pixel lies outside the spiral.
    phase   = {1'b0, angle} - {1'b0, ring};
    arm3    = 3'(phase[5:0] >> (6 - ARM_BITS));
    gap     = phase[5-ARM_BITS];
    pal_idx = arm3 + pal_off;
    lit     = bus.active && !phase[6] && !gap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rgb <= 6'd0;
    else        bus.rgb <= lit ? pal_lut(pal_idx) : 6'd0;
  end

endmodule

// File: doc/radial_sector_gen.md
RADIAL_SECTOR_GEN -- requirements
Module: radial_sector_gen

Interface
REQ-001 SHALL have parameter H_CENTER, default 320, horizontal centre pixel.
REQ-002 SHALL have parameter V_CENTER, default 240, vertical centre line.
REQ-003 SHALL have parameter ARM_BITS, default 2, log2 of arm count; legal values 1..3.
REQ-004 SHALL have parameter RING_SHIFT, default 4, radius right-shift setting ring width; legal values 2..4.
REQ-005 SHALL have parameter SWING_FRAMES, default 120, ping-pong half-period in frames; legal values 2..255.
REQ-006 SHALL have ports: clk  in  1  system clock.
REQ-007 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: x  in  10  pixel column; y  in  10  pixel line.
REQ-009 SHALL have ports: active  in  1  visible-area flag; next_frame  in  1  one-cycle frame pulse.
REQ-010 SHALL have ports: step_size  in  3  per-frame rotation step; mode  in  2  motion mode.
REQ-011 SHALL have ports: rgb  out  6  registered RRGGBB pixel colour.

Function
REQ-012 SHALL hold an 8-bit rotation accumulator rot_acc; rot_off = rot_acc[7:2].
REQ-013 SHALL sample mode only on cycles with next_frame=1, acting on rot_acc in that same cycle: 0 add step_size; 1 subtract step_size; 2 ping-pong; 3 freeze (no change). All arithmetic wraps mod 256.
REQ-014 Ping-pong SHALL use a 2-state FSM (FWD, REV) and an 8-bit frame counter: FWD adds step_size, REV subtracts.
REQ-015 The ping-pong counter SHALL increment on each mode-2 pulse; on the pulse where it equals SWING_FRAMES-1, SHALL apply the current direction, toggle the state and clear the counter.
REQ-016 A next_frame pulse with mode!=2 SHALL force state FWD and clear the counter, so mode 2 always begins FWD from count 0.
REQ-017 Geometry SHALL be: dx=|x-H_CENTER|, dy=|y-V_CENTER|, radius=dx+dy (10 bits), ring=(radius>>RING_SHIFT) truncated to 6 bits.
REQ-018 angle SHALL be {x>=H_CENTER, y>=V_CENTER, dx>dy, 3'b000} + rot_off, 6-bit wrap.
REQ-019 phase SHALL be the 7-bit value {0,angle}-{0,ring}.
REQ-020 arm index SHALL be phase[5 -: ARM_BITS]; gap bit SHALL be phase[5-ARM_BITS].
REQ-021 Palette index SHALL be (arm index + pal_off) mod 8 into: 0 010001, 1 100011, 2 111010, 3 001110, 4 110000, 5 000011, 6 101101, 7 011111.
REQ-022 rgb SHALL register, one clk after x/y/active, the palette colour when active=1, phase[6]=0 and gap=0; otherwise 000000.
REQ-023 A next_frame pulse SHALL affect pixels only from the cycle after rot_acc updates; no bypass.

Reset
REQ-024 rst_n low SHALL asynchronously clear rot_acc, the ping-pong counter, pal_off, the palette frame counter and rgb, and set state FWD, including mid-swing.
REQ-025 With rst_n low, outputs SHALL hold reset values regardless of next_frame.

Configuration
REQ-026 With macro RADIAL_PALETTE_CYCLE_EN defined, a 6-bit frame counter SHALL count every next_frame pulse regardless of mode; on wrap 63->0, 3-bit pal_off SHALL increment mod 8.
REQ-027 Without RADIAL_PALETTE_CYCLE_EN, pal_off SHALL be constant 0 and the palette frame counter SHALL not exist.

Verification
REQ-028 Reset, default parameters, x=320, y=240, active=1 -> next cycle rgb=001110 (angle 48, ring 0, arm 3).
REQ-029 Reset, x=0, y=0, active=1 -> rgb=000000 (ring 35 > angle 8, phase[6]=1); same centre pixel with active=0 -> 000000.
REQ-030 mode=0, step_size=4, 4 pulses -> rot_acc=16, rot_off=4; then mode=1, step_size=1, 17 pulses -> rot_acc=255.
REQ-031 SWING_FRAMES=4, mode=2, step_size=1, 5 pulses from reset -> rot_acc 1,2,3,4 then 3; state REV after 4th pulse; pulse with mode=3 -> rot_acc unchanged, state FWD.
REQ-032 RADIAL_PALETTE_CYCLE_EN defined, 64 pulses -> pal_off=1, centre pixel rgb=110000; macro undefined -> stays 001110.
REQ-033 rst_n asserted mid ping-pong (counter=2, REV) -> rgb, rot_acc, counter clear immediately without clk; after release, first mode-2 pulse adds step.
